// File: rtl/boom_data_array_arbiter.sv
// boom_data_array_arbiter
//   Shares the L1D data array (one read port, one write port) between NREAD
//   read requesters (round-robin) and NWRITE write requesters (fixed priority,
//   index 0 highest). A read that hits the same row and an overlapping way of
//   the granted write is skipped in favour of the next eligible read. Reads
//   are tracked through the 2-cycle array latency so resp_valid/resp_id/
//   resp_way_en line up with the array's registered response data.
//
//   Optional: BOOM_DARB_STARVE_EN -- when the read at the head of round-robin
//   order has been skipped for a collision STARVE_LIMIT cycles in a row, all
//   write grants are withheld for one cycle so that read gets through.
//
// Ports
//   clock, reset                      clock, synchronous active-high reset
//   rd_req_valid/way_en/addr, ready   read requesters (flattened slices)
//   rd_s1_kill                        cancels the response of last cycle's read
//   wr_req_valid/way_en/addr/data     write requesters (flattened slices)
//   wr_req_ready                      write grant
//   arr_rd_*, arr_wr_*                array port controls
//   resp_valid, resp_id, resp_way_en  response tag aligned with array io_resp

// Per-read-lane collision detect against the granted write.
module boom_darb_rd_lane #(
  parameter int WAYS  = 8,
  parameter int ROW_W = 9
) (
  input  logic [WAYS-1:0]  rd_way_en,
  input  logic [ROW_W-1:0] rd_row,
  input  logic             wr_valid,
  input  logic [WAYS-1:0]  wr_way_en,
  input  logic [ROW_W-1:0] wr_row,
  output logic             collide
);
  assign collide = wr_valid && (rd_row == wr_row) && |(rd_way_en & wr_way_en);
endmodule

module boom_data_array_arbiter #(
  parameter int NREAD        = 3,
  parameter int NWRITE       = 2,
  parameter int WAYS         = 8,
  parameter int ADDR_W       = 12,
  parameter int ROW_LSB      = 3,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  localparam int ID_W  = (NREAD  > 1) ? $clog2(NREAD)  : 1,
  localparam int WID_W = (NWRITE > 1) ? $clog2(NWRITE) : 1,
  localparam int ROW_W = ADDR_W - ROW_LSB
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREAD-1:0]         rd_req_valid,
  input  logic [NREAD*WAYS-1:0]    rd_req_way_en,
  input  logic [NREAD*ADDR_W-1:0]  rd_req_addr,
  output logic [NREAD-1:0]         rd_req_ready,
  input  logic                     rd_s1_kill,
  input  logic [NWRITE-1:0]        wr_req_valid,
  input  logic [NWRITE*WAYS-1:0]   wr_req_way_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_req_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_req_data,
  output logic [NWRITE-1:0]        wr_req_ready,
  output logic                     arr_rd_valid,
  output logic [WAYS-1:0]          arr_rd_way_en,
  output logic [ADDR_W-1:0]        arr_rd_addr,
  output logic                     arr_wr_valid,
  output logic [WAYS-1:0]          arr_wr_way_en,
  output logic [ADDR_W-1:0]        arr_wr_addr,
  output logic [DATA_W-1:0]        arr_wr_data,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [WAYS-1:0]          resp_way_en
);

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_order [NREAD];
  logic [NREAD-1:0] rd_collide;
  logic             rd_any, head_seen, starve_evt, wr_hold, wr_any;
  logic [ID_W-1:0]  rd_sel;
  logic [WID_W-1:0] wr_sel;

  // s1/s2 track the read through SRAM access and the io_resp register
  logic             s1_valid, s2_valid;
  logic [ID_W-1:0]  s1_id, s2_id;
  logic [WAYS-1:0]  s1_way, s2_way;

  // ---- write arbitration: lowest index wins ----
  always_comb begin
    wr_any = 1'b0;
    wr_sel = '0;
    if (!reset && !wr_hold) begin
      for (int i = NWRITE-1; i >= 0; i--) begin
        if (wr_req_valid[i]) begin
          wr_any = 1'b1;
          wr_sel = WID_W'(i);
        end
      end
    end
  end

  assign wr_req_ready  = wr_any ? (NWRITE'(1) << wr_sel) : '0;
  assign arr_wr_valid  = wr_any;
  assign arr_wr_way_en = wr_req_way_en[wr_sel*WAYS +: WAYS];
  assign arr_wr_addr   = wr_req_addr[wr_sel*ADDR_W +: ADDR_W];
  assign arr_wr_data   = wr_req_data[wr_sel*DATA_W +: DATA_W];

  // ---- per-lane collision check and round-robin visiting order ----
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ID_W:0] sum;
    assign sum = {1'b0, rr_ptr} + (ID_W+1)'(g);
    assign rr_order[g] = (sum >= (ID_W+1)'(NREAD)) ? ID_W'(sum - (ID_W+1)'(NREAD))
                                                   : sum[ID_W-1:0];
    boom_darb_rd_lane #(.WAYS(WAYS), .ROW_W(ROW_W)) u_lane (
      .rd_way_en (rd_req_way_en[g*WAYS +: WAYS]),
      .rd_row    (rd_req_addr[g*ADDR_W+ROW_LSB +: ROW_W]),
      .wr_valid  (wr_any),
      .wr_way_en (arr_wr_way_en),
      .wr_row    (arr_wr_addr[ADDR_W-1:ROW_LSB]),
      .collide   (rd_collide[g])
    );
  end

  // ---- read arbitration: first valid, non-colliding lane from rr_ptr ----
  // starve_evt flags that the head-of-order read was skipped for a collision.
  always_comb begin
    rd_any     = 1'b0;
    rd_sel     = '0;
    head_seen  = 1'b0;
    starve_evt = 1'b0;
    if (!reset) begin
      for (int k = 0; k < NREAD; k++) begin
        if (rd_req_valid[rr_order[k]]) begin
          if (!head_seen) begin
            head_seen  = 1'b1;
            starve_evt = rd_collide[rr_order[k]];
          end
          if (!rd_any && !rd_collide[rr_order[k]]) begin
            rd_any = 1'b1;
            rd_sel = rr_order[k];
          end
        end
      end
    end
  end

  assign rd_req_ready  = rd_any ? (NREAD'(1) << rd_sel) : '0;
  assign arr_rd_valid  = rd_any;
  assign arr_rd_way_en = rd_req_way_en[rd_sel*WAYS +: WAYS];
  assign arr_rd_addr   = rd_req_addr[rd_sel*ADDR_W +: ADDR_W];

  // ---- pointer and read pipeline ----
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_way   <= '0;
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_way   <= '0;
    end else begin
      if (rd_any)
        rr_ptr <= (rd_sel == ID_W'(NREAD-1)) ? '0 : rd_sel + 1'b1;
      s1_valid <= rd_any;
      s1_id    <= rd_sel;
      s1_way   <= arr_rd_way_en;
      // a killed read still occupies the array but produces no response
      s2_valid <= s1_valid & ~rd_s1_kill;
      s2_id    <= s1_id;
      s2_way   <= s1_way;
    end
  end

  assign resp_valid  = s2_valid;
  assign resp_id     = s2_id;
  assign resp_way_en = s2_way;

`ifdef BOOM_DARB_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;

  // reaching the limit withholds writes for exactly one cycle
  assign wr_hold = (starve_cnt == SC_W'(STARVE_LIMIT));

  always_ff @(posedge clock) begin
    if (reset || wr_hold || !starve_evt) starve_cnt <= '0;
    else                                 starve_cnt <= starve_cnt + 1'b1;
  end
`else
  assign wr_hold = 1'b0;
  wire unused_starve = starve_evt ^ (STARVE_LIMIT == 0);
`endif

endmodule

// File: tb/tb_boom_data_array_arbiter.sv
module tb_boom_data_array_arbiter;
  localparam int NR = 3, NW = 2, WY = 8, AW = 12, DW = 64, LIMIT = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     rd_req_valid;
  logic [NR*WY-1:0]  rd_req_way_en;
  logic [NR*AW-1:0]  rd_req_addr;
  logic [NR-1:0]     rd_req_ready;
  logic              rd_s1_kill;
  logic [NW-1:0]     wr_req_valid;
  logic [NW*WY-1:0]  wr_req_way_en;
  logic [NW*AW-1:0]  wr_req_addr;
  logic [NW*DW-1:0]  wr_req_data;
  logic [NW-1:0]     wr_req_ready;
  logic              arr_rd_valid, arr_wr_valid, resp_valid;
  logic [WY-1:0]     arr_rd_way_en, arr_wr_way_en, resp_way_en;
  logic [AW-1:0]     arr_rd_addr, arr_wr_addr;
  logic [DW-1:0]     arr_wr_data;
  logic [1:0]        resp_id;

  boom_data_array_arbiter dut (
    .clock(clock), .reset(reset),
    .rd_req_valid(rd_req_valid), .rd_req_way_en(rd_req_way_en),
    .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready), .rd_s1_kill(rd_s1_kill),
    .wr_req_valid(wr_req_valid), .wr_req_way_en(wr_req_way_en),
    .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data), .wr_req_ready(wr_req_ready),
    .arr_rd_valid(arr_rd_valid), .arr_rd_way_en(arr_rd_way_en), .arr_rd_addr(arr_rd_addr),
    .arr_wr_valid(arr_wr_valid), .arr_wr_way_en(arr_wr_way_en), .arr_wr_addr(arr_wr_addr),
    .arr_wr_data(arr_wr_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_way_en(resp_way_en)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // stimulus for the current cycle
  bit            rv [NR];
  logic [WY-1:0] rw [NR];
  logic [AW-1:0] ra [NR];
  bit            wv [NW];
  logic [WY-1:0] ww [NW];
  logic [AW-1:0] wa [NW];
  logic [DW-1:0] wd [NW];
  bit            kill, rst;

  // reference model state
  typedef struct { int due; int id; logic [WY-1:0] way; } pend_t;
  pend_t pq[$];
  int    ptr = 0, cyc = 0, starve = 0;
  bit    hold = 0;

  function automatic bit hits(int r, int w);
    return ((ra[r] >> 3) == (wa[w] >> 3)) && ((rw[r] & ww[w]) != 0);
  endfunction

  task automatic idle();
    for (int i = 0; i < NR; i++) begin rv[i] = 0; rw[i] = '0; ra[i] = '0; end
    for (int i = 0; i < NW; i++) begin wv[i] = 0; ww[i] = '0; wa[i] = '0; wd[i] = '0; end
    kill = 0; rst = 0;
  endtask

  // drive at negedge, check #1 later, advance model across posedge
  task automatic step();
    int  wwin, rwin, best, headd, d;
    bit  headcol, exp_rv;
    int  exp_id;
    logic [WY-1:0] exp_way;
    for (int i = 0; i < NR; i++) begin
      rd_req_valid[i] = rv[i]; rd_req_way_en[i*WY +: WY] = rw[i]; rd_req_addr[i*AW +: AW] = ra[i];
    end
    for (int i = 0; i < NW; i++) begin
      wr_req_valid[i] = wv[i]; wr_req_way_en[i*WY +: WY] = ww[i];
      wr_req_addr[i*AW +: AW] = wa[i]; wr_req_data[i*DW +: DW] = wd[i];
    end
    reset = rst; rd_s1_kill = kill;
    #1;
    wwin = -1;
    if (!rst && !hold)
      for (int i = NW-1; i >= 0; i--) if (wv[i]) wwin = i;
    // read winner: smallest round-robin distance from ptr among eligible lanes
    rwin = -1; best = NR; headd = NR; headcol = 0;
    if (!rst)
      for (int i = 0; i < NR; i++) if (rv[i]) begin
        d = (i - ptr + NR) % NR;
        if (d < headd) begin headd = d; headcol = (wwin >= 0) && hits(i, wwin); end
        if (!((wwin >= 0) && hits(i, wwin)) && d < best) begin best = d; rwin = i; end
      end
    chk("rd_ready", 64'(rd_req_ready), (rwin >= 0) ? 64'(1) << rwin : 64'd0);
    chk("wr_ready", 64'(wr_req_ready), (wwin >= 0) ? 64'(1) << wwin : 64'd0);
    chk("arr_rd_valid", 64'(arr_rd_valid), 64'(rwin >= 0));
    chk("arr_wr_valid", 64'(arr_wr_valid), 64'(wwin >= 0));
    if (rwin >= 0) begin
      chk("arr_rd_addr", 64'(arr_rd_addr), 64'(ra[rwin]));
      chk("arr_rd_way", 64'(arr_rd_way_en), 64'(rw[rwin]));
    end
    if (wwin >= 0) begin
      chk("arr_wr_addr", 64'(arr_wr_addr), 64'(wa[wwin]));
      chk("arr_wr_way", 64'(arr_wr_way_en), 64'(ww[wwin]));
      chk("arr_wr_data", arr_wr_data, wd[wwin]);
    end
    exp_rv = 0; exp_id = 0; exp_way = '0;
    foreach (pq[j]) if (pq[j].due == cyc) begin exp_rv = 1; exp_id = pq[j].id; exp_way = pq[j].way; end
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("resp_id", 64'(resp_id), 64'(exp_id));
      chk("resp_way", 64'(resp_way_en), 64'(exp_way));
    end
    @(posedge clock);
    for (int j = pq.size()-1; j >= 0; j--)
      if (pq[j].due <= cyc || (kill && pq[j].due == cyc+1)) pq.delete(j);
    if (rst) begin
      pq.delete(); ptr = 0; starve = 0; hold = 0;
    end else begin
      if (rwin >= 0) begin
        pq.push_back('{cyc+2, rwin, rw[rwin]});
        ptr = (rwin + 1) % NR;
      end
`ifdef BOOM_DARB_STARVE_EN
      starve = (hold || !headcol) ? 0 : starve + 1;
      hold   = (starve == LIMIT);
`else
      hold = 0; starve = headcol ? 0 : starve;
`endif
    end
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    idle(); rst = 1; reset = 1;
    rd_req_valid = '0; rd_req_way_en = '0; rd_req_addr = '0; rd_s1_kill = 0;
    wr_req_valid = '0; wr_req_way_en = '0; wr_req_addr = '0; wr_req_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    step();                               // reset state
    chk("reset_resp_id", 64'(resp_id), 64'd0);
    chk("reset_resp_way", 64'(resp_way_en), 64'd0);
    idle(); step();

    // single read -> response two cycles later
    rv[0] = 1; ra[0] = 12'h040; rw[0] = 8'h01; step();
    idle(); repeat (3) step();

    // all three reads held: round-robin rotation
    for (int i = 0; i < NR; i++) begin rv[i] = 1; ra[i] = 12'(12'h100 + 8*i); rw[i] = 8'h01; end
    repeat (6) step();
    idle(); repeat (2) step();

    // same row, overlapping way: write wins; disjoint way: both go
    wv[0] = 1; wa[0] = 12'h040; ww[0] = 8'h04; wd[0] = 64'hA5A5_0000_1234_5678;
    rv[0] = 1; ra[0] = 12'h040; rw[0] = 8'h04; step();
    chk("collide_rd_blocked", 64'(rd_req_ready), 64'd0);
    rw[0] = 8'h02; step();

    // both writers: refill has priority
    idle(); wv[0] = 1; wv[1] = 1; wd[0] = 64'h1111; wd[1] = 64'h2222; wa[1] = 12'h080; step();

    // kill the read granted last cycle; following read still responds
    idle(); rv[1] = 1; ra[1] = 12'h010; rw[1] = 8'h10; step();
    rv[1] = 1; kill = 1; ra[1] = 12'h018; step();
    idle(); repeat (3) step();

    // reset one cycle after a grant drops the in-flight read
    rv[2] = 1; ra[2] = 12'h020; rw[2] = 8'h80; step();
    idle(); rst = 1; step();
    rst = 0; repeat (3) step();

    // colliding write held: starvation relief (if built in)
    wv[0] = 1; wa[0] = 12'h040; ww[0] = 8'h01; wd[0] = 64'hBEEF;
    rv[0] = 1; ra[0] = 12'h040; rw[0] = 8'h01;
    repeat (6) step();
    idle(); repeat (2) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        rv[i] = ($urandom_range(0, 1) == 1);
        rw[i] = 8'(1 << $urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
        ra[i] = 12'(12'h040 + ($urandom_range(0, 3) << 3) + $urandom_range(0, 7));
      end
      for (int i = 0; i < NW; i++) begin
        wv[i] = ($urandom_range(0, 4) < 2);
        ww[i] = 8'(1 << $urandom_range(0, 3));
        wa[i] = 12'(12'h040 + ($urandom_range(0, 3) << 3) + $urandom_range(0, 7));
        wd[i] = {$urandom, $urandom};
      end
      kill = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
